bus_rr_sched: RTL
=================

Name: bus_rr_sched

Overview:
- Round-robin scheduler that shares a single broadcast bus among `drvrs` source FIFOs.
- Each cycle it selects one pending source, pops one packet, and decodes the destination byte. It then pushes the packet to one destination FIFO, or to all of them on broadcast, honouring per-destination backpressure.
- Sits between the per-driver FIFOs and the bus fabric. It is the sequencing controller for the shared packet bus.

Parameters:
- drvrs, 4, number of source/destination ports (2..16)
- pckg_sz, 16, packet width in bits; destination ID is pkt[pckg_sz-1 -: 8]
- broadcast, 8'hFF, destination ID meaning "all ports except source"
- max_wait, 255, cycles a PUSH may stay blocked before the packet is dropped

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- pndng  input  drvrs  source i FIFO non-empty; head word valid on D_pop (show-ahead)
- D_pop  input  drvrs*pckg_sz  head words, slice i = D_pop[i*pckg_sz +: pckg_sz]
- pop  output  drvrs  one-hot, one-cycle pop strobe to the granted source
- full  input  drvrs  destination i cannot accept a push this cycle
- push  output  drvrs  push strobe(s) to destination FIFO(s)
- D_push  output  pckg_sz  packet driven to destinations, valid while push != 0
- grant_id  output  $clog2(drvrs)  index of current/last granted source
- busy  output  1  high in any state other than IDLE
- drop_cnt  output  8  saturating count of dropped packets (invalid destination or timeout)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pop, push, D_push, grant_id, drop_cnt and busy all 0.
  - The round-robin pointer is set to drvrs-1, so source 0 has first priority.
  - Any packet in flight is discarded.
- FSM (registered) has four states: IDLE, POP, ROUTE, PUSH.
- IDLE:
  - If pndng != 0, search from ptr+1 with wrap and take the first set bit as the grant.
  - Register grant_id and go to POP. Otherwise stay in IDLE.
- POP (exactly 1 cycle):
  - pop[grant_id]=1.
  - pkt_reg <= D_pop slice grant_id.
  - ptr <= grant_id.
  - Next state is ROUTE.
- ROUTE (1 cycle): dest = pkt_reg top byte.
  - dest == broadcast: mask = all ones except bit grant_id.
  - dest < drvrs and dest != grant_id: mask = one-hot(dest).
  - Otherwise the packet is invalid: drop, drop_cnt++ (saturate at 255), go to IDLE.
  - Valid packet: clear the wait counter and go to PUSH.
- PUSH:
  - If (full & mask) == 0: push = mask and D_push = pkt_reg for one cycle, then IDLE.
  - Delivery is atomic: no partial broadcast. All targeted destinations must be non-full in the same cycle.
  - If blocked, increment the wait counter. When the counter reaches max_wait, drop the packet, drop_cnt++, and go to IDLE with no push.
- Timing:
  - Minimum turnaround is 4 cycles per packet.
  - pop occurs 1 cycle after pndng is sampled in IDLE; push occurs 3 cycles after.
- D_push holds its last value outside push cycles; receivers must qualify it with push.
- pndng dropping while in POP is a source protocol error: the pop is still issued and the packet is still captured.
- Fairness: a source that stays pending is granted within drvrs grants.

Decomposition:
- Package bus_sched_pkg holds:
  - state enum (IDLE, POP, ROUTE, PUSH)
  - DEST_HI = pckg_sz-1
  - drop-counter width
  - function dest_mask(dest, src)
- One sub-module, rr_pick: combinational round-robin priority finder (inputs req vector and ptr, outputs grant index and a valid flag). It is reusable elsewhere.

Test Plan:
- Reset then single packet: pndng=0001, D_pop[0]=16'h0255 -> pop=0001 at cycle+1, push=0100 with D_push=16'h0255 at cycle+3; drop_cnt=0.
- All four sources pending continuously, each targeting (src+1)%4 -> grant order 0,1,2,3,0..., one push every 4 cycles, no source granted twice before the others.
- Broadcast from source 2, D_pop[2]=16'hFF3C, full=0 -> push=1011 in one cycle with D_push=16'hFF3C.
- Invalid destinations: packet 16'h07AA from source 1 (4 drivers), then 16'h01AA from source 1 (self) -> no push, drop_cnt 0->1->2, FSM back to IDLE after ROUTE.
- Backpressure: dest 3 with full[3]=1 held 10 cycles, then released -> push=1000 in the cycle after full deasserts. Separately, full[3] held 300 cycles with max_wait=255 -> no push, drop_cnt++.
- Reset asserted during PUSH -> push/pop drop to 0 immediately (asynchronous). After release, the next grant goes to source 0 and the old packet is never delivered.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared constants, state encodings and destination decoding for the
// round-robin bus scheduler.
package bus_sched_pkg;

  localparam int unsigned DEST_W    = 8;
  localparam int unsigned DROP_W    = 8;
  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned SRC_W     = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_POP   = 2'd1;
  localparam logic [1:0] ST_ROUTE = 2'd2;
  localparam logic [1:0] ST_PUSH  = 2'd3;

  // Target mask for a packet from src; all-zero means the destination is invalid.
  function automatic logic [MAX_PORTS-1:0] dest_mask(
    input logic [DEST_W-1:0] dest,
    input logic [SRC_W-1:0]  src,
    input logic [DEST_W-1:0] bcast,
    input int unsigned       nports
  );
    logic [MAX_PORTS-1:0] ports;
    ports = (nports >= MAX_PORTS) ? '1 : MAX_PORTS'((32'd1 << nports) - 32'd1);
    dest_mask = '0;
    if (dest == bcast)
      dest_mask = ports & ~(MAX_PORTS'(1) << src);
    else if ((32'(dest) < nports) && (dest != DEST_W'(src)))
      dest_mask = MAX_PORTS'(1) << dest;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request after ptr, with wrap.
module rr_pick #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0]         req,
  input  logic [$clog2(n)-1:0] ptr,
  output logic [$clog2(n)-1:0] grant_c,
  output logic                 valid_c
);

  localparam int unsigned IDX_W = $clog2(n);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_c = ptr;
    valid_c = 1'b0;
    idx     = ptr;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = IDX_W'((32'(ptr) + k) % n);
      if (!valid_c && req[idx]) begin
        valid_c = 1'b1;
        grant_c = idx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler: pops one packet from a pending source FIFO and
// delivers it atomically to one or all destination FIFOs.
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int unsigned       drvrs     = 4,
  parameter int unsigned       pckg_sz   = 16,
  parameter logic [DEST_W-1:0] broadcast = 8'hFF,
  parameter int unsigned       max_wait  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic                       busy,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int unsigned IDX_W  = $clog2(drvrs);
  localparam int unsigned WAIT_W = $clog2(max_wait + 1);

  logic [1:0]         state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt, grant_nxt, pick_idx;
  logic               pick_vld;
  logic [pckg_sz-1:0] pkt_reg, pkt_nxt, dpush_nxt;
  logic [drvrs-1:0]   mask_reg, mask_nxt, route_mask, pop_nxt, push_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [DROP_W-1:0]  drop_nxt, drop_inc;
  logic               busy_nxt;
  logic [DEST_W-1:0]  dest;
  logic [pckg_sz-1:0] src_word [drvrs];

  for (genvar i = 0; i < drvrs; i++) begin : g_unpack
    assign src_word[i] = D_pop[i*pckg_sz +: pckg_sz];
  end

  rr_pick #(.n(drvrs)) u_pick (
    .req     (pndng),
    .ptr     (ptr),
    .grant_c (pick_idx),
    .valid_c (pick_vld)
  );

  assign dest       = pkt_reg[pckg_sz-1 -: DEST_W];
  assign route_mask = drvrs'(dest_mask(dest, SRC_W'(grant_id), broadcast, drvrs));
  assign drop_inc   = (drop_cnt == '1) ? drop_cnt : drop_cnt + DROP_W'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= IDX_W'(drvrs - 1);
      grant_id <= '0;
      pkt_reg  <= '0;
      mask_reg <= '0;
      wait_cnt <= '0;
      drop_cnt <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
      pkt_reg  <= pkt_nxt;
      mask_reg <= mask_nxt;
      wait_cnt <= wait_nxt;
      drop_cnt <= drop_nxt;
      pop      <= pop_nxt;
      push     <= push_nxt;
      D_push   <= dpush_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next state; the push strobe is decided one edge ahead so it lands registered
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    pkt_nxt   = pkt_reg;
    mask_nxt  = mask_reg;
    wait_nxt  = wait_cnt;
    drop_nxt  = drop_cnt;
    pop_nxt   = '0;
    push_nxt  = '0;
    dpush_nxt = D_push;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_idx;
          pop_nxt   = drvrs'(1) << pick_idx;
          state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        pkt_nxt   = src_word[grant_id];
        ptr_nxt   = grant_id;
        state_nxt = ST_ROUTE;
      end
      ST_ROUTE: begin
        if (route_mask == '0) begin
          drop_nxt  = drop_inc;
          state_nxt = ST_IDLE;
        end else begin
          mask_nxt  = route_mask;
          wait_nxt  = '0;
          state_nxt = ST_PUSH;
          if ((full & route_mask) == '0) begin
            push_nxt  = route_mask;
            dpush_nxt = pkt_reg;
          end
        end
      end
      ST_PUSH: begin
        if (push != '0) begin
          state_nxt = ST_IDLE;
        end else if ((full & mask_reg) == '0) begin
          push_nxt  = mask_reg;
          dpush_nxt = pkt_reg;
        end else if (wait_cnt == WAIT_W'(max_wait - 1)) begin
          drop_nxt  = drop_inc;
          state_nxt = ST_IDLE;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
